// File: rtl/ram_arbiter.sv
// Round-robin front end that shares one single-port synchronous RAM between two requesters.
// RAM pins are driven from registers; read data returns to the issuing port 3 cycles after its grant.

module ram_arbiter_port #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hit,
    input  logic [DW-1:0] data,
    output logic          rvalid,
    output logic [DW-1:0] rdata
);
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= hit;
            if (hit) rdata <= data;
        end
    end
endmodule

module ram_arbiter #(
    parameter int AW        = 5,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          cen,
    output logic          wen,
    output logic [AW-1:0] S_addr,
    output logic [DW-1:0] S_din,
    input  logic [DW-1:0] S_dout
);
    localparam int NP     = 2;
    localparam int STAGES = 2;
    localparam int BW     = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [NP-1:0]      req, gnt, hit, rvalid;
    cmd_t [NP-1:0]      cmd;
    cmd_t               sel;
    logic               any, win, owner, last;
    logic [BW-1:0]      burst_cnt;
    logic [STAGES:1]    vld_pipe, port_pipe;
    logic [NP-1:0][DW-1:0] rdata;

    assign req    = {m1_req, m0_req};
    assign cmd[0] = '{wr: m0_wr, addr: m0_addr, wdata: m0_wdata};
    assign cmd[1] = '{wr: m1_wr, addr: m1_addr, wdata: m1_wdata};
    assign owner  = (state == OWN1);
    assign sel    = cmd[win];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // The owner keeps the RAM until its burst is spent while the other side waits.
    always_comb begin
        any = 1'b0;
        win = 1'b0;
        case (state)
            IDLE: begin
                if (req[0] && req[1]) begin
                    any = 1'b1;
                    win = ~last;
                end else if (req[0] || req[1]) begin
                    any = 1'b1;
                    win = req[1];
                end
            end
            OWN0, OWN1: begin
                if (req[owner] && (!req[~owner] || burst_cnt < BMAX)) begin
                    any = 1'b1;
                    win = owner;
                end else if (req[~owner]) begin
                    any = 1'b1;
                    win = ~owner;
                end
            end
            default: ;
        endcase
        if (reset) any = 1'b0;
        state_nxt = !any ? IDLE : (win ? OWN1 : OWN0);
    end

    always_comb begin
        gnt = '0;
        if (any) gnt[win] = 1'b1;
    end

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            last      <= 1'b1;
            burst_cnt <= '0;
        end else if (any) begin
            last <= win;
            if (state == IDLE || win != owner) burst_cnt <= BW'(1);
            else if (burst_cnt != BMAX)        burst_cnt <= burst_cnt + BW'(1);
        end else begin
            burst_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cen    <= 1'b0;
            wen    <= 1'b0;
            S_addr <= '0;
            S_din  <= '0;
        end else if (any) begin
            cen    <= 1'b1;
            wen    <= sel.wr;
            S_addr <= sel.addr;
            S_din  <= sel.wdata;
        end else begin
            cen <= 1'b0;
            wen <= 1'b0;
        end
    end

    // Read tags ride alongside the RAM access so S_dout can be steered on arrival.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            port_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], any & ~sel.wr};
            port_pipe <= {port_pipe[STAGES-1:1], win};
        end
    end

    for (genvar p = 0; p < NP; p++) begin : g_port
        assign hit[p] = vld_pipe[STAGES] && (port_pipe[STAGES] == 1'(p));
        ram_arbiter_port #(.DW(DW)) u_port (
            .clk    (clk),
            .reset  (reset),
            .hit    (hit[p]),
            .data   (S_dout),
            .rvalid (rvalid[p]),
            .rdata  (rdata[p])
        );
    end

    assign m0_rvalid = rvalid[0];
    assign m1_rvalid = rvalid[1];
    assign m0_rdata  = rdata[0];
    assign m1_rdata  = rdata[1];
endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized and directed bench for ram_arbiter: a reference arbitration/memory model fills a
// read scoreboard; a negedge monitor checks grants, RAM pins and read returns against it.

module tb_ram_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ram_clr = 1'b1;
    logic          m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          cen, wen;
    logic [AW-1:0] S_addr;
    logic [DW-1:0] S_din, S_dout;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .cen(cen), .wen(wen), .S_addr(S_addr), .S_din(S_din), .S_dout(S_dout)
    );

    always #5 clk = ~clk;

    // single-port RAM with registered read
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
        end else if (cen) begin
            if (wen) mem[S_addr] <= S_din;
            else     S_dout <= mem[S_addr];
        end
    end

    typedef struct { int port; logic [DW-1:0] data; int due; } rd_t;
    rd_t           sb[$];
    int            total = 0, bad = 0, cyc = 0;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            own = -1, run = 0, lastp = 1;
    bit            armed = 0;
    logic          e_cen, e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
    logic [DW-1:0] e_rdata [2];
    bit            g0, g1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit            r[2], w[2], rv[2], ev[2], g[2];
        logic [AW-1:0] a[2];
        logic [DW-1:0] d[2], rd[2];
        int            win, oth;
        cyc++;
        r  = '{m0_req, m1_req};     w  = '{m0_wr, m1_wr};
        a  = '{m0_addr, m1_addr};   d  = '{m0_wdata, m1_wdata};
        g  = '{m0_gnt, m1_gnt};     rv = '{m0_rvalid, m1_rvalid};
        rd = '{m0_rdata, m1_rdata};
        if (armed) begin
            chk("cen", DW'(cen), DW'(e_cen));
            chk("wen", DW'(wen), DW'(e_wen));
            chk("S_addr", DW'(S_addr), DW'(e_addr));
            chk("S_din", S_din, e_din);
            for (int p = 0; p < 2; p++) begin
                ev[p] = sb.size() > 0 && sb[0].due == cyc && sb[0].port == p;
                if (ev[p]) e_rdata[p] = sb[0].data;
                chk($sformatf("rvalid%0d", p), DW'(rv[p]), DW'(ev[p]));
                chk($sformatf("rdata%0d", p), rd[p], e_rdata[p]);
            end
            if (sb.size() > 0 && sb[0].due == cyc) void'(sb.pop_front());
        end
        if (reset) begin
            chk("gnt0_rst", DW'(g[0]), '0);
            chk("gnt1_rst", DW'(g[1]), '0);
            sb.delete();
            own = -1; run = 0; lastp = 1;
            e_cen = 0; e_wen = 0; e_addr = '0; e_din = '0;
            e_rdata[0] = '0; e_rdata[1] = '0;
            armed = 1;
        end else begin
            win = -1;
            if (own < 0) begin
                if (r[0] && r[1]) win = 1 - lastp;
                else if (r[0])    win = 0;
                else if (r[1])    win = 1;
            end else begin
                oth = 1 - own;
                if (r[own] && (!r[oth] || run < MB)) win = own;
                else if (r[oth])                     win = oth;
            end
            chk("gnt0", DW'(g[0]), DW'(win == 0));
            chk("gnt1", DW'(g[1]), DW'(win == 1));
            if (win >= 0) begin
                run   = (own == win) ? ((run < MB) ? run + 1 : MB) : 1;
                own   = win;
                lastp = win;
                e_cen = 1; e_wen = w[win]; e_addr = a[win]; e_din = d[win];
                if (w[win]) ref_mem[a[win]] = d[win];
                else        sb.push_back('{port: win, data: ref_mem[a[win]], due: cyc + 3});
            end else begin
                own = -1; run = 0;
                e_cen = 0; e_wen = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        g0 = m0_gnt;
        g1 = m1_gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input bit rq, input bit wr, input int a, input int d);
        if (p == 0) begin
            m0_req = rq; m0_wr = wr; m0_addr = AW'(a); m0_wdata = DW'(d);
        end else begin
            m1_req = rq; m1_wr = wr; m1_addr = AW'(a); m1_wdata = DW'(d);
        end
    endtask

    // hold a request on port p through n grants, stepping address/data after each grant
    task automatic burst(input int p, input bit wr, input int base, input int n, input int dbase);
        int i = 0, guard = 0;
        set_port(p, 1, wr, base, dbase);
        while (i < n && guard < 64) begin
            tick();
            guard++;
            if ((p == 0) ? g0 : g1) begin
                i++;
                if (i < n) set_port(p, 1, wr, base + i, dbase + i);
                else       set_port(p, 0, 0, 0, 0);
            end
        end
        set_port(p, 0, 0, 0, 0);
        chk("grant_count", DW'(i), DW'(n));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int seq[16];
        int ga, gb;
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
        tick(); tick();
        reset = 0; ram_clr = 0;
        idle(2);

        // write then read back on M0
        burst(0, 1, 5, 1, 32'hDEADBEEF);
        burst(0, 0, 5, 1, 0);
        idle(5);

        // write followed immediately by a read of the same address
        set_port(0, 1, 1, 9, 32'h1234_5678);
        tick();
        set_port(0, 1, 0, 9, 0);
        tick();
        chk("wr_rd_grant", DW'(g0), 1);
        set_port(0, 0, 0, 0, 0);
        idle(5);

        // both requesters from IDLE after reset: 4-grant bursts alternating, M0 first
        reset = 1; tick(); reset = 0;
        ga = 0; gb = 0;
        set_port(0, 1, 0, 0, 0);
        set_port(1, 1, 0, 16, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            seq[i] = g0 ? 0 : (g1 ? 1 : -1);
            if (g0) begin ga++; set_port(0, 1, 0, ga, 0); end
            if (g1) begin gb++; set_port(1, 1, 0, 16 + gb, 0); end
        end
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) chk($sformatf("burst_seq%0d", i), DW'(seq[i]), DW'((i / 4) % 2));
        idle(5);

        // alternating single reads
        burst(0, 0, 5, 1, 0);
        burst(1, 0, 9, 1, 0);
        burst(0, 0, 9, 1, 0);
        idle(5);

        // M1 preload then pipelined reads
        burst(1, 1, 0, 4, 100);
        burst(1, 0, 0, 4, 0);
        idle(6);

        // reset the cycle after a read grant: the read must never return
        burst(0, 0, 5, 1, 0);
        reset = 1; tick(); reset = 0;
        chk("rst_cen", DW'(cen), 0);
        chk("rst_rvalid0", DW'(m0_rvalid), 0);
        chk("rst_rvalid1", DW'(m1_rvalid), 0);
        idle(6);
        set_port(0, 1, 0, 1, 0);
        set_port(1, 1, 0, 2, 0);
        tick();
        chk("rst_m0_first", DW'(g0), 1);
        set_port(0, 0, 0, 0, 0);
        tick();
        chk("m1_after", DW'(g1), 1);
        set_port(1, 0, 0, 0, 0);
        idle(5);

        // owner drops its request while the other waits
        set_port(0, 1, 0, 3, 0);
        tick();
        set_port(1, 1, 0, 4, 0);
        tick();
        chk("own0_keeps", DW'(g0), 1);
        set_port(0, 0, 0, 0, 0);
        tick();
        chk("yield_m1", DW'(g1), 1);
        set_port(1, 0, 0, 0, 0);
        idle(5);

        // random traffic with occasional abandoned requests and resets
        for (int c = 0; c < 4000; c++) begin
            tick();
            reset = ($urandom_range(0, 299) == 0);
            for (int p = 0; p < 2; p++) begin
                bit rq = (p == 0) ? m0_req : m1_req;
                bit gg = (p == 0) ? g0 : g1;
                if (gg || !rq)
                    set_port(p, $urandom_range(0, 99) < 55, $urandom_range(0, 1) == 1,
                             int'($urandom_range(0, 7)), int'($urandom));
                else if ($urandom_range(0, 19) == 0)
                    set_port(p, 0, 0, 0, 0);
            end
        end
        reset = 0;
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
        idle(8);
        chk("sb_drained", DW'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port round-robin arbiter and sequencer for the 32x32 single-port synchronous RAM (cen/wen/S_addr/S_din/S_dout, registered read).
- Sits between two requesters (M0, M1) and the RAM.
- Serialises their read/write commands, drives the RAM control pins from registers, and returns read data with a valid pulse to the requester that issued the read.
- A burst counter lets an owner keep the RAM for up to MAX_BURST consecutive accesses before yielding to a waiting requester.

Parameters:
- AW, 5, address width (RAM depth 2^AW).
- DW, 32, data width.
- MAX_BURST, 4, max consecutive grants to one owner while the other requester waits (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  M0 command request; held until granted.
- m0_wr  in  1  M0 command type: 1 = write, 0 = read.
- m0_addr  in  AW  M0 address.
- m0_wdata  in  DW  M0 write data.
- m0_gnt  out  1  combinational; command accepted at this rising edge.
- m0_rvalid  out  1  registered one-cycle pulse; m0_rdata valid.
- m0_rdata  out  DW  registered read data for M0.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: identical to the M0 ports, for M1.
- cen  out  1  RAM chip enable (registered).
- wen  out  1  RAM write enable (registered).
- S_addr  out  AW  RAM address (registered).
- S_din  out  DW  RAM write data (registered).
- S_dout  in  DW  RAM read data; valid the cycle after a cen=1, wen=0 cycle.

Behaviour:
- Reset values (at the rising edge with reset=1):
  - cen=0, wen=0, S_addr=0, S_din=0.
  - m*_rvalid=0, m*_rdata=0.
  - state=IDLE, last=M1 (so M0 has first priority), burst_cnt=0.
  - Read tags cleared.
  - m*_gnt=0 while reset=1.
- FSM states: IDLE, OWN0, OWN1. Exactly one gnt per cycle at most; gnt is a function of state, burst_cnt and the req inputs.
  - IDLE:
    - Only one req: grant it.
    - Both req: grant the one that is not last.
    - No req: stay IDLE.
  - OWNx:
    - Grant x if mx_req=1 and (other req=0 or burst_cnt<MAX_BURST).
    - Else grant the other requester if its req=1.
    - Else go to IDLE.
  - Next state = OWN(granted); IDLE if no grant.
  - last is updated to the granted port on every grant.
- burst_cnt:
  - Set to 1 on a grant to a port different from the current owner, or on a grant from IDLE.
  - Incremented (saturating at MAX_BURST) on a repeat grant to the owner.
  - Cleared on entering IDLE.
- Command issue:
  - On the edge ending grant cycle t: cen<=1, wen<=wr, S_addr<=addr, S_din<=wdata of the winner.
  - With no grant: cen<=0, wen<=0; S_addr and S_din hold.
  - Back-to-back grants give back-to-back RAM accesses (throughput 1 per cycle).
- Read return:
  - Each granted read pushes a tag {valid, port} through a 2-stage pipeline, aligned to cycles t+1 and t+2.
  - At the edge ending t+2, S_dout is latched into the tagged port's rdata and that port's rvalid is set for cycle t+3.
  - Read latency is 3 cycles from the grant cycle.
  - The other port's rdata is held; rvalid is otherwise 0.
- Writes produce no rvalid.
- Write followed by a read to the same address in the next cycle returns the new data; the RAM write completes before the read.
- Requester contract: req/wr/addr/wdata are stable while req=1 and gnt=0. If a requester drops req without a grant, the request is abandoned with no side effect.
- Simultaneous events: an rvalid return and a new grant to the same port in the same cycle are independent and both happen.
- Reset mid-operation: in-flight read tags are discarded, so no rvalid is produced for those reads. A RAM access already issued still completes in the RAM.

Test Plan:
1. Single write then read:
   - M0 writes addr 5 = 0xDEADBEEF, then reads addr 5.
   - Required: m0_gnt each request; cen=1/wen=1 then cen=1/wen=0 on S_* the cycle after each grant; m0_rvalid=1 with m0_rdata=0xDEADBEEF 3 cycles after the read grant; m1_rvalid stays 0.
2. Simultaneous requests from IDLE after reset:
   - Both req in the same cycle with both requesters continuously requesting, each with distinct addresses.
   - Required: M0 granted first; M0 holds for 4 consecutive grants (MAX_BURST=4); then M1 gets 4; strict alternation of 4-bursts.
3. Alternating single requests:
   - M0 and M1 each pulse one read.
   - Required: each gets its own rvalid/rdata; rdata of the non-tagged port is unchanged.
4. Pipelined reads:
   - M1 reads addrs 0,1,2,3 back-to-back after preloading mem[i]=i+100.
   - Required: m1_rvalid high for 4 consecutive cycles with rdata 100,101,102,103.
5. Reset mid-operation:
   - Assert reset one cycle after a read grant.
   - Required: cen=0, all rvalid=0 next cycle, no late rvalid; state IDLE with M0 priority.
6. Owner yields when idle:
   - In OWN0, M0 drops req while M1 requests.
   - Required: M1 granted the same cycle; burst_cnt=1.
